// File: rtl/wb_port_sched.sv
// wb_port_sched: write-back port scheduler for six functional-unit lanes.
// Each lane buffers results in a 2-entry FIFO and always drives its own
// register-file write port. When several lane heads carry the same
// destination tag, only one of them is granted in a cycle, so two ports
// never write the same physical register together.
// Optional feature macro: WB_SCHED_STARVE_GUARD_EN. When it is defined,
// a lane that has been blocked for three consecutive cycles wins its tag
// conflict against lower lanes.
module wb_port_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic [5:0]                fu_valid_i,
  output logic [5:0]                fu_ready_o,
  input  logic [6*TAG_WIDTH-1:0]    fu_tag_i,
  input  logic [6*DATA_WIDTH-1:0]   fu_data_i,
  output logic [5:0]                wr_en_o,
  output logic [6*TAG_WIDTH-1:0]    wr_tag_o,
  output logic [6*DATA_WIDTH-1:0]   wr_data_o
);

  localparam int LANES = 6;

  logic [TAG_WIDTH-1:0]  mem_tag   [LANES][2];
  logic [DATA_WIDTH-1:0] mem_data  [LANES][2];
  logic [1:0]            count     [LANES];
  logic [LANES-1:0]      rd_ptr;
  logic [LANES-1:0]      wr_ptr;
  logic [TAG_WIDTH-1:0]  head_tag  [LANES];
  logic [DATA_WIDTH-1:0] head_data [LANES];
  logic [LANES-1:0]      cand;
  logic [LANES-1:0]      push;
  logic [LANES-1:0]      grant;
  logic [LANES-1:0]      starved;

  // Per-lane FIFO status: head entry, candidate flag, ready and accepted push.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      head_tag[k]   = mem_tag[k][rd_ptr[k]];
      head_data[k]  = mem_data[k][rd_ptr[k]];
      cand[k]       = (count[k] != 2'd0);
      fu_ready_o[k] = (count[k] != 2'd2);
      push[k]       = fu_valid_i[k] && (count[k] != 2'd2);
    end
  end

`ifdef WB_SCHED_STARVE_GUARD_EN
  logic [1:0] blk_cnt [LANES];

  // A lane whose counter has saturated is treated as starved this cycle.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      starved[k] = (blk_cnt[k] == 2'd3);
    end
  end

  // Count consecutive cycles in which a lane had a head but was not granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LANES; k++) blk_cnt[k] <= 2'd0;
    end else if (flush_i) begin
      for (int k = 0; k < LANES; k++) blk_cnt[k] <= 2'd0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (grant[k] || !cand[k]) begin
          blk_cnt[k] <= 2'd0;
        end else if (blk_cnt[k] != 2'd3) begin
          blk_cnt[k] <= blk_cnt[k] + 2'd1;
        end else begin
          blk_cnt[k] <= blk_cnt[k];
        end
      end
    end
  end
`else
  // Pure fixed priority: no lane is ever promoted.
  always_comb begin
    starved = {LANES{1'b0}};
  end
`endif

  // Tag-conflict arbitration. Starved lanes are considered first (lowest
  // index first), then the rest in index order; a lane is granted unless an
  // already granted lane holds the same tag. With no starved lanes this is
  // plain lowest-index-wins priority.
  always_comb begin
    logic blk;
    blk   = 1'b0;
    grant = {LANES{1'b0}};
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < LANES; k++) begin
        blk = 1'b0;
        for (int j = 0; j < LANES; j++) begin
          if (grant[j] && (head_tag[j] == head_tag[k])) begin
            blk = 1'b1;
          end else begin
            blk = blk;
          end
        end
        if (cand[k] && (starved[k] == (p == 0)) && !blk) begin
          grant[k] = 1'b1;
        end else begin
          grant[k] = grant[k];
        end
      end
    end
  end

  // FIFO storage, pointers, occupancy and registered write-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= {LANES{1'b0}};
      wr_ptr    <= {LANES{1'b0}};
      wr_en_o   <= 6'b000000;
      wr_tag_o  <= {(6*TAG_WIDTH){1'b0}};
      wr_data_o <= {(6*DATA_WIDTH){1'b0}};
      for (int k = 0; k < LANES; k++) begin
        count[k] <= 2'd0;
        for (int e = 0; e < 2; e++) begin
          mem_tag[k][e]  <= {TAG_WIDTH{1'b0}};
          mem_data[k][e] <= {DATA_WIDTH{1'b0}};
        end
      end
    end else if (flush_i) begin
      // Drop everything buffered and this cycle's pushes; tag/data hold.
      rd_ptr  <= {LANES{1'b0}};
      wr_ptr  <= {LANES{1'b0}};
      wr_en_o <= 6'b000000;
      for (int k = 0; k < LANES; k++) count[k] <= 2'd0;
    end else begin
      wr_en_o <= grant;
      for (int k = 0; k < LANES; k++) begin
        if (push[k]) begin
          mem_tag[k][wr_ptr[k]]  <= fu_tag_i[k*TAG_WIDTH +: TAG_WIDTH];
          mem_data[k][wr_ptr[k]] <= fu_data_i[k*DATA_WIDTH +: DATA_WIDTH];
          wr_ptr[k]              <= ~wr_ptr[k];
        end
        if (grant[k]) begin
          rd_ptr[k]                              <= ~rd_ptr[k];
          wr_tag_o[k*TAG_WIDTH +: TAG_WIDTH]     <= head_tag[k];
          wr_data_o[k*DATA_WIDTH +: DATA_WIDTH]  <= head_data[k];
        end
        count[k] <= count[k] + {1'b0, push[k]} - {1'b0, grant[k]};
      end
    end
  end

endmodule

// File: tb/tb_wb_port_sched.sv
// Directed self-checking bench for wb_port_sched (default parameters).
// Expectations that depend on WB_SCHED_STARVE_GUARD_EN follow the same macro.
module tb_wb_port_sched;

  logic         clk;
  logic         rst;
  logic         flush;
  logic [5:0]   fu_valid;
  logic [5:0]   fu_ready;
  logic [35:0]  fu_tag;
  logic [191:0] fu_data;
  logic [5:0]   wr_en;
  logic [35:0]  wr_tag;
  logic [191:0] wr_data;

  int n_checks;
  int n_errors;

  wb_port_sched #(.DATA_WIDTH(32), .TAG_WIDTH(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .fu_valid_i (fu_valid),
    .fu_ready_o (fu_ready),
    .fu_tag_i   (fu_tag),
    .fu_data_i  (fu_data),
    .wr_en_o    (wr_en),
    .wr_tag_o   (wr_tag),
    .wr_data_o  (wr_data)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tg, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tg, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int k, input logic [5:0] t, input logic [31:0] d);
    fu_valid[k]       = 1'b1;
    fu_tag[k*6 +: 6]  = t;
    fu_data[k*32 +: 32] = d;
  endtask

  task automatic do_flush();
    fu_valid = 6'b000000;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
  endtask

  logic [5:0] exp_en;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    fu_valid = 6'b000000;
    fu_tag   = 36'h0;
    fu_data  = 192'h0;

    // Reset state.
    step();
    step();
    check("rst_wr_en", 64'(wr_en), 64'h0);
    check("rst_wr_tag", 64'(wr_tag), 64'h0);
    check("rst_wr_data_lo", wr_data[63:0], 64'h0);
    check("rst_ready", 64'(fu_ready), 64'h3f);
    rst = 1'b0;
    step();

    // Single result on lane 2.
    set_lane(2, 6'd5, 32'hDEADBEEF);
    step();                                   // edge N
    fu_valid = 6'b000000;
    check("single_lat_n", 64'(wr_en), 64'h0);
    step();                                   // edge N+1
    check("single_en", 64'(wr_en), 64'h04);
    check("single_tag", 64'(wr_tag[12 +: 6]), 64'd5);
    check("single_data", 64'(wr_data[64 +: 32]), 64'hDEADBEEF);
    step();
    check("single_clear", 64'(wr_en), 64'h0);
    check("single_tag_hold", 64'(wr_tag[12 +: 6]), 64'd5);

    // Tag conflict lanes 0 and 3.
    set_lane(0, 6'd9, 32'h11);
    set_lane(3, 6'd9, 32'h33);
    step();
    fu_valid = 6'b000000;
    step();
    check("conf_c1_en", 64'(wr_en), 64'h01);
    check("conf_c1_tag", 64'(wr_tag[0 +: 6]), 64'd9);
    step();
    check("conf_c2_en", 64'(wr_en), 64'h08);
    check("conf_c2_tag", 64'(wr_tag[18 +: 6]), 64'd9);
    check("conf_c2_data", 64'(wr_data[96 +: 32]), 64'h33);
    step();
    check("conf_idle", 64'(wr_en), 64'h0);

    // Backpressure on lane 1 blocked by lane 0 on tag 7.
    set_lane(0, 6'd7, 32'hB0);
    set_lane(1, 6'd7, 32'hA1);
    step();                                   // E0
    set_lane(0, 6'd7, 32'hB1);
    set_lane(1, 6'd7, 32'hA2);
    step();                                   // E1
    check("bp_e1_en", 64'(wr_en), 64'h01);
    check("bp_e1_d0", 64'(wr_data[0 +: 32]), 64'hB0);
    check("bp_e1_ready", 64'(fu_ready), 64'h3d);
    set_lane(0, 6'd7, 32'hB2);
    set_lane(1, 6'd7, 32'hA3);
    step();                                   // E2, lane 1 full: A3 held
    check("bp_e2_en", 64'(wr_en), 64'h01);
    check("bp_e2_d0", 64'(wr_data[0 +: 32]), 64'hB1);
    check("bp_e2_ready1", 64'(fu_ready[1]), 64'h0);
    fu_valid[0] = 1'b0;
    step();                                   // E3
    check("bp_e3_en", 64'(wr_en), 64'h01);
    check("bp_e3_d0", 64'(wr_data[0 +: 32]), 64'hB2);
    step();                                   // E4
    check("bp_e4_en", 64'(wr_en), 64'h02);
    check("bp_e4_d1", 64'(wr_data[32 +: 32]), 64'hA1);
    check("bp_e4_ready1", 64'(fu_ready[1]), 64'h1);
    step();                                   // E5, A3 accepted
    fu_valid = 6'b000000;
    check("bp_e5_en", 64'(wr_en), 64'h02);
    check("bp_e5_d1", 64'(wr_data[32 +: 32]), 64'hA2);
    step();
    check("bp_e6_en", 64'(wr_en), 64'h02);
    check("bp_e6_d1", 64'(wr_data[32 +: 32]), 64'hA3);
    step();
    check("bp_e7_en", 64'(wr_en), 64'h0);

    // Flush with all lanes loaded.
    for (int k = 0; k < 6; k++) set_lane(k, 6'd3, 32'h100 + 32'(k));
    step();
    for (int k = 0; k < 6; k++) set_lane(k, 6'd3, 32'h200 + 32'(k));
    step();
    check("fl_pre_ready", 64'(fu_ready), 64'h01);
    check("fl_pre_en", 64'(wr_en), 64'h01);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    fu_valid = 6'b000000;
    check("fl_en", 64'(wr_en), 64'h0);
    check("fl_ready", 64'(fu_ready), 64'h3f);
    for (int i = 0; i < 3; i++) begin
      step();
      check("fl_no_stale", 64'(wr_en), 64'h0);
    end

    // Asynchronous reset with all ports writing.
    for (int k = 0; k < 6; k++) set_lane(k, 6'(10 + k), 32'h300 + 32'(k));
    step();
    for (int k = 0; k < 6; k++) set_lane(k, 6'(20 + k), 32'h400 + 32'(k));
    step();
    check("ar_pre_en", 64'(wr_en), 64'h3f);
    check("ar_pre_tag5", 64'(wr_tag[30 +: 6]), 64'd15);
    #2;
    rst = 1'b1;
    #1;
    check("ar_en", 64'(wr_en), 64'h0);
    check("ar_tag", 64'(wr_tag), 64'h0);
    check("ar_data_hi", wr_data[191:128], 64'h0);
    #1;
    rst      = 1'b0;
    fu_valid = 6'b000000;
    step();
    check("ar_post_ready", 64'(fu_ready), 64'h3f);
    check("ar_post_en", 64'(wr_en), 64'h0);
    step();
    check("ar_post_en2", 64'(wr_en), 64'h0);

    // Starvation: lane 0 streams tag 4, lane 1 holds tag 4.
    set_lane(0, 6'd4, 32'hC0);
    set_lane(1, 6'd4, 32'h1111);
    step();                                   // E0
    fu_valid[1] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      set_lane(0, 6'd4, 32'hC0 + 32'(i));
      step();                                 // Ei
      exp_en = 6'h01;
`ifdef WB_SCHED_STARVE_GUARD_EN
      if (i == 4) exp_en = 6'h02;
`endif
      check("starve_en", 64'(wr_en), 64'(exp_en));
      if (exp_en == 6'h02) begin
        check("starve_tag1", 64'(wr_tag[6 +: 6]), 64'd4);
        check("starve_data1", 64'(wr_data[32 +: 32]), 64'h1111);
      end
    end
    do_flush();
    check("end_ready", 64'(fu_ready), 64'h3f);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_port_sched.md
WB_PORT_SCHED -- requirements
Module: wb_port_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the result data width per lane.
REQ-002 SHALL have parameter TAG_WIDTH, default 6, the destination physical-register tag width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port flush_i, input, 1, synchronous pipeline flush.
REQ-006 SHALL have port fu_valid_i, input, 6, per-lane functional-unit result valid.
REQ-007 SHALL have port fu_ready_o, output, 6, per-lane ready; a lane result transfers when valid and ready are both high at a rising edge.
REQ-008 SHALL have port fu_tag_i, input, 6*TAG_WIDTH, per-lane destination tag; lane k occupies bits [k*TAG_WIDTH +: TAG_WIDTH].
REQ-009 SHALL have port fu_data_i, input, 6*DATA_WIDTH, per-lane result data, packed the same way.
REQ-010 SHALL have port wr_en_o, output, 6, registered per-port write enables toward the 6-write-port register cells.
REQ-011 SHALL have port wr_tag_o, output, 6*TAG_WIDTH, registered per-port write tag.
REQ-012 SHALL have port wr_data_o, output, 6*DATA_WIDTH, registered per-port write data.

Function
REQ-013 SHALL provide one 2-entry FIFO per lane; lane k always drives write port k.
REQ-014 SHALL drive fu_ready_o[k] high iff lane k FIFO holds fewer than 2 entries. There is no push-while-full bypass.
REQ-015 SHALL treat each non-empty FIFO head as a candidate each cycle.
REQ-016 SHALL grant candidate k unless a granted candidate j<k carries an identical tag.
REQ-017 As a consequence of REQ-016, no two asserted wr_en_o bits SHALL ever carry equal wr_tag_o values.
REQ-018 SHALL pop granted heads at the rising edge. wr_en_o[k], wr_tag_o and wr_data_o lane k SHALL be loaded from the granted head at that same edge.
REQ-019 Non-granted candidates SHALL remain at head unchanged and retry the next cycle.
REQ-020 SHALL clear wr_en_o[k] at any edge where lane k is not granted. wr_tag_o and wr_data_o SHALL hold their last value.
REQ-021 Latency: a result accepted at edge N into an empty lane, and not blocked, SHALL appear with wr_en_o high in the cycle following edge N+1.
REQ-022 Simultaneous push and pop on one lane at an edge SHALL both take effect, leaving the count unchanged.
REQ-023 FIFO pointers SHALL wrap modulo 2, and order within a lane SHALL be preserved.
REQ-024 flush_i high at an edge SHALL empty all FIFOs, clear wr_en_o, and discard that cycle's pushes; fu_ready_o SHALL then be 6'b111111.

Reset
REQ-025 rst high SHALL immediately, without waiting for a clock edge, empty all FIFOs and set wr_en_o=0, wr_tag_o=0, wr_data_o=0, and any starvation counters to 0.
REQ-026 After rst deasserts, fu_ready_o SHALL be 6'b111111. Assertion of rst mid-transfer SHALL lose all buffered results, with no partial write.

Configuration
REQ-027 With macro WB_SCHED_STARVE_GUARD_EN defined, each lane SHALL keep a 2-bit blocked-cycle counter.
REQ-028 Under WB_SCHED_STARVE_GUARD_EN, a lane blocked 3 consecutive cycles SHALL win its tag conflict over all lower lanes next cycle; if several lanes qualify, the lowest index wins.
REQ-029 Under WB_SCHED_STARVE_GUARD_EN, a lane's counter SHALL clear on grant, flush or reset.
REQ-030 Without WB_SCHED_STARVE_GUARD_EN, no counters SHALL exist and pure fixed priority (REQ-016) SHALL apply.

Verification
REQ-031 Scenario, single result: lane 2 pushes tag 5, data 0xDEADBEEF at edge N -> wr_en_o=6'b000100 after edge N+1, lane-2 tag 5, data 0xDEADBEEF.
REQ-032 Scenario, tag conflict: lanes 0 and 3 push tag 9 at the same edge -> cycle 1 has wr_en_o=6'b000001; next cycle has wr_en_o=6'b001000 with tag 9.
REQ-033 Scenario, backpressure: 3 back-to-back pushes on lane 1 while blocked by lane 0 on the same tag -> fu_ready_o[1]=0 after the 2nd push, and the 3rd is held until a pop; order is preserved.
REQ-034 Scenario, flush: lanes 0-5 full, flush_i pulsed -> wr_en_o=0 and fu_ready_o=6'b111111 the next cycle, and no stale write ever appears.
REQ-035 Scenario, async reset: rst asserted mid-cycle with wr_en_o=6'b111111 -> outputs go to 0 before the next clock edge.
REQ-036 Scenario, starvation guard: with the guard enabled, lane 0 sends tag 4 every cycle and lane 1 holds tag 4 -> lane 1 is granted on its 4th candidate cycle; with the guard disabled, lane 1 is never granted.
